// File: rtl/vx_onehot_demux.sv
// One-hot stream demultiplexer: steers each accepted beat into a 2-entry FIFO
// on the selected output; illegal selects are consumed, dropped and counted.
module vx_onehot_demux #(
    parameter int DATAW    = 32,
    parameter int N        = 4,
    parameter int ERR_CNTW = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [DATAW-1:0]          data_in,
    input  logic [N-1:0]              sel_in,
    output logic                      ready_in,
    output logic [N-1:0]              valid_out,
    output logic [N-1:0][DATAW-1:0]   data_out,
    input  logic [N-1:0]              ready_out,
    output logic [ERR_CNTW-1:0]       err_count,
    output logic                      err_sticky
);

    localparam logic [N-1:0]        SEL_ONE = N'(1);
    localparam logic [ERR_CNTW-1:0] ERR_MAX = '1;

    logic [N-1:0][1:0]       cnt_q, cnt_d;
    logic [N-1:0]            valid_q, valid_d;
    logic [N-1:0][DATAW-1:0] head_q, head_d, tail_q, tail_d;
    logic [ERR_CNTW-1:0]     err_q, err_d;
    logic                    sticky_q, sticky_d;

    logic                    sel_legal;
    logic                    tgt_full;
    logic [N-1:0]            full_vec;
    logic [N-1:0]            push_vec;
    logic                    drop;

    // Handshake: a beat transfers on any edge where valid and ready are both
    // high; ready never looks at valid, and ready_in never looks at ready_out.
    always_comb begin
        sel_legal = (sel_in != '0) && ((sel_in & (sel_in - SEL_ONE)) == '0);
        for (int i = 0; i < N; i++) begin
            full_vec[i] = (cnt_q[i] == 2'd2);
        end
        tgt_full = |(sel_in & full_vec);
        ready_in = reset && (!sel_legal || !tgt_full);
        push_vec = (valid_in && ready_in && sel_legal) ? sel_in : '0;
        drop     = valid_in && ready_in && !sel_legal;
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < N; i++) begin
            case (cnt_q[i])
                2'd0: begin
                    if (push_vec[i]) begin
                        head_d[i] = data_in;
                        cnt_d[i]  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_vec[i] && ready_out[i]) begin
                        head_d[i] = data_in;
                    end else if (push_vec[i]) begin
                        tail_d[i] = data_in;
                        cnt_d[i]  = 2'd2;
                    end else if (ready_out[i]) begin
                        cnt_d[i]  = 2'd0;
                    end
                end
                default: begin
                    // Full: only a pop can happen, the tail slides into the head.
                    if (ready_out[i]) begin
                        head_d[i] = tail_q[i];
                        cnt_d[i]  = 2'd1;
                    end
                end
            endcase
            valid_d[i] = (cnt_d[i] != 2'd0);
        end
    end

    always_comb begin
        err_d    = err_q;
        sticky_d = sticky_q;
        if (drop) begin
            sticky_d = 1'b1;
            if (err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            valid_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            err_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = head_q;
    assign err_count  = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_vx_onehot_demux.sv
// Bench for vx_onehot_demux: directed steps plus random traffic, checked against
// per-output model queues; a second instance uses a 2-bit error counter.
module tb_vx_onehot_demux;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic [31:0]       data_in;
    logic [3:0]        sel_in;
    logic [3:0]        ready_out;

    logic              ready_in, ready_in2;
    logic [3:0]        valid_out, valid_out2;
    logic [3:0][31:0]  data_out, data_out2;
    logic [7:0]        err_count;
    logic [1:0]        err_count2;
    logic              err_sticky, err_sticky2;

    int                n_checks = 0;
    int                n_err    = 0;

    logic [31:0]       mq [4][$];
    int                err_exp;
    bit                sticky_exp;
    logic              acc;

    vx_onehot_demux #(.DATAW(32), .N(4), .ERR_CNTW(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .sel_in(sel_in), .ready_in(ready_in), .valid_out(valid_out),
        .data_out(data_out), .ready_out(ready_out), .err_count(err_count),
        .err_sticky(err_sticky)
    );

    vx_onehot_demux #(.DATAW(32), .N(4), .ERR_CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .sel_in(sel_in), .ready_in(ready_in2), .valid_out(valid_out2),
        .data_out(data_out2), .ready_out(ready_out), .err_count(err_count2),
        .err_sticky(err_sticky2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic rdy, input logic [3:0] vo,
                             input logic [3:0][31:0] dout, input logic [7:0] ec,
                             input logic es, input logic exp_rdy, input int cap);
        logic [3:0] exp_vo;
        int         exp_ec;
        for (int i = 0; i < 4; i++) exp_vo[i] = (mq[i].size() != 0);
        exp_ec = (err_exp > cap) ? cap : err_exp;
        check({tag, ".ready_in"}, rdy, exp_rdy);
        check({tag, ".valid_out"}, vo, exp_vo);
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() != 0)
                check($sformatf("%s.data_out[%0d]", tag, i), dout[i], mq[i][0]);
        end
        check({tag, ".err_count"}, ec, exp_ec[7:0]);
        check({tag, ".err_sticky"}, es, sticky_exp);
    endtask

    // Drive one cycle from a negedge, check outputs, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic [3:0] r, output logic accepted);
        bit   legal;
        int   tgt;
        logic exp_rdy;
        valid_in  = v;
        data_in   = d;
        sel_in    = s;
        ready_out = r;
        #1;
        legal = ($countones(s) == 1);
        tgt   = 0;
        for (int i = 0; i < 4; i++) if (s[i]) tgt = i;
        exp_rdy  = reset && (!legal || (mq[tgt].size() < 2));
        check_dut("dut", ready_in, valid_out, data_out, err_count, err_sticky, exp_rdy, 255);
        check_dut("dut2", ready_in2, valid_out2, data_out2, {6'd0, err_count2}, err_sticky2,
                  exp_rdy, 3);
        accepted = v && exp_rdy;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            err_exp    = 0;
            sticky_exp = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0 && r[i]) void'(mq[i].pop_front());
            if (accepted) begin
                if (legal) mq[tgt].push_back(d);
                else begin
                    err_exp    = err_exp + 1;
                    sticky_exp = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_until(input logic [31:0] d, input logic [3:0] s, input logic [3:0] r);
        logic a;
        a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, d, s, r, a);
            if (a) break;
        end
        if (!a) check("send_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] s;
        err_exp    = 0;
        sticky_exp = 1'b0;
        reset      = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        sel_in     = '0;
        ready_out  = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held: nothing accepted, outputs cleared.
        repeat (2) cycle(1'b1, 32'h1234, 4'b0001, 4'hF, acc);
        check("rst_data", data_out, 128'd0);
        check("rst_data2", data_out2, 128'd0);
        reset = 1'b1;

        // Single beat to output 2, latency 1.
        cycle(1'b1, 32'hA5A5A5A5, 4'b0100, 4'hF, acc);
        cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);
        cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);

        // Output 1 stalled: fill, backpressure, no head-of-line blocking, drain in order.
        cycle(1'b1, 32'h1, 4'b0010, 4'b1101, acc);
        cycle(1'b1, 32'h2, 4'b0010, 4'b1101, acc);
        cycle(1'b1, 32'h3, 4'b0010, 4'b1101, acc);
        cycle(1'b1, 32'h55, 4'b1000, 4'b0101, acc);
        cycle(1'b0, 32'h0, 4'b0000, 4'b0101, acc);
        send_until(32'h3, 4'b0010, 4'hF);
        repeat (3) cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);

        // Illegal selects are consumed and counted.
        cycle(1'b1, 32'hBAD0, 4'b0000, 4'hF, acc);
        cycle(1'b1, 32'hBAD1, 4'b0110, 4'hF, acc);
        cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);

        // Streaming 100 beats to output 0.
        for (int k = 0; k < 100; k++) cycle(1'b1, 32'h100 + k, 4'b0001, 4'hF, acc);
        cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 8) s = 4'(1 << $urandom_range(0, 3));
            else s = 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), $urandom, s, 4'($urandom_range(0, 15)), acc);
        end

        // Fill outputs 0 and 2, then a one-cycle reset discards everything.
        repeat (2) cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);
        cycle(1'b1, 32'hC0, 4'b0001, 4'h0, acc);
        cycle(1'b1, 32'hC1, 4'b0001, 4'h0, acc);
        cycle(1'b1, 32'hC2, 4'b0100, 4'h0, acc);
        cycle(1'b1, 32'hC3, 4'b0100, 4'h0, acc);
        reset = 1'b0;
        cycle(1'b1, 32'hDEAD, 4'b0010, 4'h0, acc);
        reset = 1'b1;
        check("post_rst_data", data_out, 128'd0);
        check("post_rst_data2", data_out2, 128'd0);
        repeat (3) cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);

        // Five illegal beats saturate the 2-bit counter at 3.
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'hE0 + k, 4'b0011, 4'hF, acc);
        cycle(1'b0, 32'h0, 4'b0000, 4'hF, acc);
        check("err_sat2", err_count2, 2'd3);
        check("err_cnt8", err_count, 8'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
